// File: rtl/sprite_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_rom_arbiter_if
// Description : Bundle of requester, ROM and read-return signals shared by
//               the sprite ROM arbiter and the blocks around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 4,
    parameter int LEN_W   = 5
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        gnt;
    logic                      busy;
    logic                      rom_en;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;
    logic                      rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic [ID_W-1:0]           rd_id;
    logic [NUM_REQ-1:0]        done;

    // Arbiter side
    modport slave (
        input  req, req_addr, req_len, rom_data,
        output gnt, busy, rom_en, rom_addr, rd_valid, rd_data, rd_id, done
    );

    // Engines + ROM side
    modport master (
        output req, req_addr, req_len, rom_data,
        input  gnt, busy, rom_en, rom_addr, rd_valid, rd_data, rd_id, done
    );
endinterface
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_rom_arbiter
// Description : Round-robin burst arbiter sharing one sprite ROM read port
//               among NUM_REQ drawing engines; returns tagged read data.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 4,
    parameter int LEN_W   = 5,
    parameter int ROM_LAT = 0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    sprite_rom_arbiter_if.slave     bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int DEPTH = ROM_LAT + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                      state_q;
    logic [ID_W-1:0]             rr_last_q;   // last granted index = owner of current burst
    logic [LEN_W-1:0]            rem_q;       // addresses left, including the one on rom_addr
    logic [NUM_REQ-1:0]          gnt_q;
    logic                        rom_en_q;
    logic [ADDR_W-1:0]           rom_addr_q;

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0]            last_q;
    logic [DEPTH-1:0][ID_W-1:0]  id_q;
    logic [DATA_W-1:0]           rd_data_q;
    logic [NUM_REQ-1:0]          done_q;

    logic                        found_d;
    logic [ID_W-1:0]             sel_idx_d;
    logic [ADDR_W-1:0]           sel_addr_d;
    logic [LEN_W-1:0]            sel_len_d;
    logic [DEPTH:0]              vld_chain_d;
    logic [DEPTH:0]              last_chain_d;
    logic [DEPTH:0][ID_W-1:0]    id_chain_d;

    // Round-robin pick: first request strictly after the last grant, with wrap
    always_comb begin
        found_d   = 1'b0;
        sel_idx_d = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_last_q) + k) % NUM_REQ;
            if (!found_d && bus.req[idx]) begin
                found_d   = 1'b1;
                sel_idx_d = ID_W'(idx);
            end
        end
    end

    // Burst parameters of the winner; a zero length still reads one word
    always_comb begin
        sel_addr_d = bus.req_addr[sel_idx_d*ADDR_W +: ADDR_W];
        sel_len_d  = bus.req_len[sel_idx_d*LEN_W +: LEN_W];
        if (sel_len_d == '0) begin
            sel_len_d = LEN_W'(1);
        end
    end

    // Stage 0 of the return pipe is the read being issued this cycle
    always_comb begin
        vld_chain_d  = {vld_q, rom_en_q};
        last_chain_d = {last_q, rom_en_q && (rem_q == LEN_W'(1))};
        id_chain_d   = {id_q, rr_last_q};
    end

    // Control FSM: grant, address generation, drain until last datum returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_last_q  <= ID_W'(NUM_REQ - 1);
            rem_q      <= '0;
            gnt_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    gnt_q <= '0;
                    if (found_d) begin
                        state_q    <= S_BURST;
                        gnt_q      <= NUM_REQ'(1) << sel_idx_d;
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= sel_addr_d;
                        rem_q      <= sel_len_d;
                        rr_last_q  <= sel_idx_d;
                    end
                end
                S_BURST: begin
                    gnt_q <= '0;
                    if (rem_q > LEN_W'(1)) begin
                        rom_addr_q <= rom_addr_q + ADDR_W'(1);
                        rem_q      <= rem_q - LEN_W'(1);
                    end else begin
                        rom_en_q <= 1'b0;
                        state_q  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // done_q marks the cycle the final datum is on rd_data
                    if (|done_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Return pipe: valid/last/id shift alongside the ROM latency; data sampled at its tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            last_q    <= '0;
            id_q      <= '0;
            rd_data_q <= '0;
            done_q    <= '0;
        end else begin
            vld_q  <= vld_chain_d[DEPTH-1:0];
            last_q <= last_chain_d[DEPTH-1:0];
            id_q   <= id_chain_d[DEPTH-1:0];
            if (vld_chain_d[DEPTH-1]) begin
                rd_data_q <= bus.rom_data;
            end
            if (vld_chain_d[DEPTH-1] && last_chain_d[DEPTH-1]) begin
                done_q <= NUM_REQ'(1) << id_chain_d[DEPTH-1];
            end else begin
                done_q <= '0;
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rd_valid = vld_q[DEPTH-1];
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_id    = id_q[DEPTH-1];
    assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_rom_arbiter
// Description : Directed testbench for sprite_rom_arbiter with a
//               combinational ROM (latency 0) and a 2-cycle ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(19), .DATA_W(4), .LEN_W(5)) b0 ();
    sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(19), .DATA_W(4), .LEN_W(5)) b1 ();

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(19), .DATA_W(4), .LEN_W(5), .ROM_LAT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(19), .DATA_W(4), .LEN_W(5), .ROM_LAT(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    // ROM contents: low nibble of the address xor 5
    function automatic logic [3:0] rom_f(input logic [18:0] a);
        return a[3:0] ^ 4'h5;
    endfunction

    // Combinational ROM for dut0, two-stage registered ROM for dut1
    logic [18:0] a1;
    logic [18:0] a2;
    assign b0.rom_data = rom_f(b0.rom_addr);
    always @(posedge clk) begin
        a1 <= b1.rom_addr;
        a2 <= a1;
    end
    assign b1.rom_data = rom_f(a2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        total++; if (b0.gnt !== 4'b0) $display("FAIL rst_gnt0: got %b want 0000", b0.gnt); else passed++;
        total++; if (b0.busy !== 1'b0) $display("FAIL rst_busy0: got %b want 0", b0.busy); else passed++;
        total++; if (b0.rom_en !== 1'b0) $display("FAIL rst_rom_en0: got %b want 0", b0.rom_en); else passed++;
        total++; if (b0.rom_addr !== 19'd0) $display("FAIL rst_rom_addr0: got %h want 0", b0.rom_addr); else passed++;
        total++; if (b0.rd_valid !== 1'b0) $display("FAIL rst_rd_valid0: got %b want 0", b0.rd_valid); else passed++;
        total++; if (b0.done !== 4'b0) $display("FAIL rst_done0: got %b want 0000", b0.done); else passed++;
        total++; if (b1.busy !== 1'b0) $display("FAIL rst_busy1: got %b want 0", b1.busy); else passed++;
        total++; if (b1.rd_valid !== 1'b0) $display("FAIL rst_rd_valid1: got %b want 0", b1.rd_valid); else passed++;
        rst_n = 1'b1;
    endtask

    // ROM_LAT=0, requester 0, base 10, length 4
    task automatic test_single_burst;
        b0.req_addr[0 +: 19] = 19'd10;
        b0.req_len[0 +: 5]   = 5'd4;
        b0.req               = 4'b0001;
        tick; // cycle 1
        total++; if (b0.gnt !== 4'b0001) $display("FAIL t1_gnt: got %b want 0001", b0.gnt); else passed++;
        total++; if (b0.rom_en !== 1'b1) $display("FAIL t1_rom_en_c1: got %b want 1", b0.rom_en); else passed++;
        total++; if (b0.rom_addr !== 19'd10) $display("FAIL t1_rom_addr_c1: got %0d want 10", b0.rom_addr); else passed++;
        total++; if (b0.busy !== 1'b1) $display("FAIL t1_busy_c1: got %b want 1", b0.busy); else passed++;
        total++; if (b0.rd_valid !== 1'b0) $display("FAIL t1_rd_valid_c1: got %b want 0", b0.rd_valid); else passed++;
        b0.req = 4'b0000;
        for (int c = 2; c <= 5; c++) begin
            logic [18:0] ea;
            logic [3:0]  ed;
            ea = (c <= 4) ? 19'(10 + c - 1) : 19'd13;
            ed = rom_f(19'(10 + c - 2));
            tick;
            total++; if (b0.gnt !== 4'b0) $display("FAIL t1_gnt_c%0d: got %b want 0000", c, b0.gnt); else passed++;
            total++; if (b0.rom_en !== (c <= 4)) $display("FAIL t1_rom_en_c%0d: got %b want %b", c, b0.rom_en, (c <= 4)); else passed++;
            total++; if (b0.rom_addr !== ea) $display("FAIL t1_rom_addr_c%0d: got %0d want %0d", c, b0.rom_addr, ea); else passed++;
            total++; if (b0.rd_valid !== 1'b1) $display("FAIL t1_rd_valid_c%0d: got %b want 1", c, b0.rd_valid); else passed++;
            total++; if (b0.rd_id !== 2'd0) $display("FAIL t1_rd_id_c%0d: got %0d want 0", c, b0.rd_id); else passed++;
            total++; if (b0.rd_data !== ed) $display("FAIL t1_rd_data_c%0d: got %h want %h", c, b0.rd_data, ed); else passed++;
            total++; if (b0.done !== ((c == 5) ? 4'b0001 : 4'b0000)) $display("FAIL t1_done_c%0d: got %b", c, b0.done); else passed++;
        end
        tick; // cycle 6
        total++; if (b0.busy !== 1'b0) $display("FAIL t1_busy_c6: got %b want 0", b0.busy); else passed++;
        total++; if (b0.rd_valid !== 1'b0) $display("FAIL t1_rd_valid_c6: got %b want 0", b0.rd_valid); else passed++;
        total++; if (b0.done !== 4'b0) $display("FAIL t1_done_c6: got %b want 0000", b0.done); else passed++;
    endtask

    // All four requesting, length 1: grant 0,1,2,3,0,1, one grant every 3 cycles
    task automatic test_round_robin;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            b0.req_addr[i*19 +: 19] = 19'(i * 16);
            b0.req_len[i*5 +: 5]    = 5'd1;
        end
        b0.req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            logic [3:0] eg;
            eg = 4'b0001 << (k % 4);
            tick; // BURST
            total++; if (b0.gnt !== eg) $display("FAIL rr_gnt_%0d: got %b want %b", k, b0.gnt, eg); else passed++;
            total++; if (b0.rom_addr !== 19'((k % 4) * 16)) $display("FAIL rr_addr_%0d: got %0d want %0d", k, b0.rom_addr, (k % 4) * 16); else passed++;
            tick; // DRAIN
            total++; if (b0.rd_id !== 2'(k % 4)) $display("FAIL rr_id_%0d: got %0d want %0d", k, b0.rd_id, k % 4); else passed++;
            total++; if (b0.done !== eg) $display("FAIL rr_done_%0d: got %b want %b", k, b0.done, eg); else passed++;
            tick; // IDLE
            total++; if (b0.busy !== 1'b0) $display("FAIL rr_idle_%0d: got busy %b want 0", k, b0.busy); else passed++;
        end
        b0.req = 4'b0000;
        tick;
        total++; if (b0.busy !== 1'b0) $display("FAIL rr_quiet: got busy %b want 0", b0.busy); else passed++;
    endtask

    // Address wraps modulo 2**19
    task automatic test_wrap;
        logic [18:0] wa [4];
        logic [3:0]  wd [4];
        wa = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
        wd = '{4'hB, 4'hA, 4'h5, 4'h4};
        b0.req_addr[0 +: 19] = 19'h7FFFE;
        b0.req_len[0 +: 5]   = 5'd4;
        b0.req               = 4'b0001;
        tick;
        total++; if (b0.rom_addr !== wa[0]) $display("FAIL wrap_addr0: got %h want %h", b0.rom_addr, wa[0]); else passed++;
        b0.req = 4'b0000;
        for (int i = 1; i < 4; i++) begin
            tick;
            total++; if (b0.rom_addr !== wa[i]) $display("FAIL wrap_addr%0d: got %h want %h", i, b0.rom_addr, wa[i]); else passed++;
            total++; if (b0.rd_data !== wd[i-1]) $display("FAIL wrap_data%0d: got %h want %h", i - 1, b0.rd_data, wd[i-1]); else passed++;
        end
        tick;
        total++; if (b0.rd_data !== wd[3]) $display("FAIL wrap_data3: got %h want %h", b0.rd_data, wd[3]); else passed++;
        total++; if (b0.done !== 4'b0001) $display("FAIL wrap_done: got %b want 0001", b0.done); else passed++;
        tick;
    endtask

    // Zero length reads exactly one word
    task automatic test_len_zero;
        int en_cnt;
        int vld_cnt;
        int done_cnt;
        en_cnt = 0; vld_cnt = 0; done_cnt = 0;
        b0.req_addr[3*19 +: 19] = 19'd100;
        b0.req_len[3*5 +: 5]    = 5'd0;
        b0.req                  = 4'b1000;
        tick;
        b0.req = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            if (b0.rom_en === 1'b1) en_cnt++;
            if (b0.rd_valid === 1'b1) begin
                vld_cnt++;
                total++; if (b0.rd_id !== 2'd3) $display("FAIL len0_id: got %0d want 3", b0.rd_id); else passed++;
                total++; if (b0.rd_data !== 4'h1) $display("FAIL len0_data: got %h want 1", b0.rd_data); else passed++;
            end
            if (b0.done !== 4'b0) begin
                done_cnt++;
                total++; if (b0.done !== 4'b1000) $display("FAIL len0_done_bits: got %b want 1000", b0.done); else passed++;
            end
            tick;
        end
        total++; if (en_cnt != 1) $display("FAIL len0_rom_en_cycles: got %0d want 1", en_cnt); else passed++;
        total++; if (vld_cnt != 1) $display("FAIL len0_rd_valid_cycles: got %0d want 1", vld_cnt); else passed++;
        total++; if (done_cnt != 1) $display("FAIL len0_done_pulses: got %0d want 1", done_cnt); else passed++;
    endtask

    // ROM_LAT=2, length 3 on dut1
    task automatic test_rom_latency;
        logic [3:0] ld [3];
        ld = '{4'h5, 4'h4, 4'h7};
        b1.req_addr[0 +: 19] = 19'h20;
        b1.req_len[0 +: 5]   = 5'd3;
        b1.req               = 4'b0001;
        tick; // cycle 1
        total++; if (b1.gnt !== 4'b0001) $display("FAIL lat_gnt: got %b want 0001", b1.gnt); else passed++;
        total++; if (b1.rd_valid !== 1'b0) $display("FAIL lat_rd_valid_c1: got %b want 0", b1.rd_valid); else passed++;
        b1.req = 4'b0000;
        for (int c = 2; c <= 3; c++) begin
            tick;
            total++; if (b1.rd_valid !== 1'b0) $display("FAIL lat_rd_valid_c%0d: got %b want 0", c, b1.rd_valid); else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            tick; // cycles 4..6
            total++; if (b1.rd_valid !== 1'b1) $display("FAIL lat_rd_valid_%0d: got %b want 1", i, b1.rd_valid); else passed++;
            total++; if (b1.rd_data !== ld[i]) $display("FAIL lat_rd_data_%0d: got %h want %h", i, b1.rd_data, ld[i]); else passed++;
            total++; if (b1.done !== ((i == 2) ? 4'b0001 : 4'b0000)) $display("FAIL lat_done_%0d: got %b", i, b1.done); else passed++;
        end
        tick; // cycle 7
        total++; if (b1.busy !== 1'b0) $display("FAIL lat_busy_c7: got %b want 0", b1.busy); else passed++;
    endtask

    // Reset during the second BURST cycle of requester 2
    task automatic test_reset_mid_burst;
        do_reset;
        b0.req_addr[2*19 +: 19] = 19'd50;
        b0.req_len[2*5 +: 5]    = 5'd4;
        b0.req                  = 4'b0100;
        tick; // cycle 1
        total++; if (b0.gnt !== 4'b0100) $display("FAIL mr_gnt2: got %b want 0100", b0.gnt); else passed++;
        tick; // cycle 2
        #2 rst_n = 1'b0;
        #1;
        total++; if (b0.gnt !== 4'b0) $display("FAIL mr_gnt: got %b want 0000", b0.gnt); else passed++;
        total++; if (b0.busy !== 1'b0) $display("FAIL mr_busy: got %b want 0", b0.busy); else passed++;
        total++; if (b0.rom_en !== 1'b0) $display("FAIL mr_rom_en: got %b want 0", b0.rom_en); else passed++;
        total++; if (b0.rom_addr !== 19'd0) $display("FAIL mr_rom_addr: got %0d want 0", b0.rom_addr); else passed++;
        total++; if (b0.rd_valid !== 1'b0) $display("FAIL mr_rd_valid: got %b want 0", b0.rd_valid); else passed++;
        total++; if (b0.rd_data !== 4'h0) $display("FAIL mr_rd_data: got %h want 0", b0.rd_data); else passed++;
        total++; if (b0.done !== 4'b0) $display("FAIL mr_done: got %b want 0000", b0.done); else passed++;
        b0.req_addr[0 +: 19] = 19'd60;
        b0.req_len[0 +: 5]   = 5'd1;
        b0.req               = 4'b0101;
        tick;
        total++; if (b0.done !== 4'b0) $display("FAIL mr_done_held: got %b want 0000", b0.done); else passed++;
        rst_n = 1'b1;
        tick;
        total++; if (b0.gnt !== 4'b0001) $display("FAIL mr_first_gnt: got %b want 0001", b0.gnt); else passed++;
        b0.req = 4'b0000;
        tick;
        total++; if (b0.done !== 4'b0001) $display("FAIL mr_done_after: got %b want 0001", b0.done); else passed++;
        tick;
        total++; if (b0.busy !== 1'b0) $display("FAIL mr_busy_end: got %b want 0", b0.busy); else passed++;
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        rst_n       = 1'b0;
        b0.req      = '0;
        b0.req_addr = '0;
        b0.req_len  = '0;
        b1.req      = '0;
        b1.req_addr = '0;
        b1.req_len  = '0;
        test_reset;
        test_single_burst;
        test_round_robin;
        test_wrap;
        test_len_zero;
        test_rom_latency;
        test_reset_mid_burst;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
